// File: rtl/ram_rom_mem_pkg.sv
// ram_rom_pkg: shared types and constants for the ram_rom_mem block.
//   state_e  : controller state (INIT reload sequence, RUN serving requests)
//   rom_init : preload value for a word address in the read-only region.
//              Returns 32 bits; the caller truncates to its data width.
package ram_rom_pkg;

  typedef enum logic {INIT, RUN} state_e;

  function automatic logic [31:0] rom_init(input logic [31:0] addr);
    case (addr)
      32'd0:   return 32'h4;
      32'd1:   return 32'hC;
      32'd2:   return 32'h6;
      32'd3:   return 32'h7;
      default: return addr;
    endcase
  endfunction

endpackage

// File: rtl/ram_rom_mem_if.sv
// ram_rom_mem_if: request/response bus of the ram_rom_mem block.
//   req_valid/req_ready : request handshake, accepted when both are high
//   req_we/addr/wdata   : write flag, word address, write data
//   rsp_valid           : one-cycle pulse, one per accepted request, in order
//   rsp_rdata/rsp_err   : read data (0 for writes), write-to-ROM flag
// Modports: master drives requests, slave (the memory) drives responses.
interface ram_rom_mem_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_rom_mem_array.sv
// ram_rom_array: DEPTH x DATA_W storage, DEPTH = 2**ADDR_W.
//   clk           : clock
//   we/waddr/wdata: synchronous write port
//   re/raddr      : synchronous read port, data lands in rdata after the edge
//   rdata         : registered read data (held when re is low)
// Storage and the read register carry no reset; the controller reloads
// the contents after every reset.
module ram_rom_array #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/ram_rom_mem.sv
// ram_rom_mem: single-port synchronous memory. Words [0, ROM_DEPTH-1] are
// read-only and preloaded with constants, the rest is writable RAM.
// After reset an INIT sequence writes one word per cycle for DEPTH cycles
// (ROM constants, RAM zeroed) before requests are accepted.
//   clk     : clock, all logic on posedge
//   rst_n   : synchronous active-low reset, restarts INIT
//   clr_req : restart INIT from RUN (only with RAMROM_CLEAR_EN defined)
//   busy    : INIT sequence running
//   bus     : request/response interface (slave side)
// Optional feature macro: RAMROM_CLEAR_EN (adds clr_req).
module ram_rom_mem
  import ram_rom_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 3,
  parameter int ROM_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef RAMROM_CLEAR_EN
  input  logic clr_req,
`endif
  output logic busy,
  ram_rom_mem_if.slave bus
);
  localparam logic [ADDR_W:0]   ROM_LIM = (ADDR_W+1)'(ROM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_wr_q, rsp_wr_d;

  logic              accept;
  logic              clr_go;
  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;

  function automatic logic is_rom(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < ROM_LIM;
  endfunction

`ifdef RAMROM_CLEAR_EN
  assign clr_go = clr_req;
`else
  assign clr_go = 1'b0;
`endif

  assign bus.req_ready = (state_q == RUN);
  assign busy          = (state_q == INIT);
  assign accept        = bus.req_valid & bus.req_ready;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    arr_we     = 1'b0;
    arr_re     = 1'b0;
    arr_waddr  = bus.req_addr;
    arr_wdata  = bus.req_wdata;
    case (state_q)
      INIT: begin
        arr_we     = 1'b1;
        arr_waddr  = init_ptr_q;
        arr_wdata  = is_rom(init_ptr_q) ? DATA_W'(rom_init(32'(init_ptr_q))) : '0;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST) begin
          state_d    = RUN;
          init_ptr_d = '0;
        end
      end
      default: begin
        if (accept) begin
          // ROM-region writes are answered with an error and never reach storage
          arr_we = bus.req_we & ~is_rom(bus.req_addr);
          arr_re = ~bus.req_we;
        end
        // A request accepted alongside a clear is still answered next cycle
        if (clr_go) begin
          state_d    = INIT;
          init_ptr_d = '0;
        end
      end
    endcase
    rsp_valid_d = accept;
    rsp_wr_d    = accept & bus.req_we;
    rsp_err_d   = accept & bus.req_we & is_rom(bus.req_addr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_ptr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_wr_q    <= rsp_wr_d;
    end
  end

  ram_rom_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (bus.req_addr),
    .rdata (arr_rdata)
  );

  // Read data register is not reset, so gate it to zero outside read responses
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = (rsp_valid_q & ~rsp_wr_q) ? arr_rdata : '0;
endmodule

// File: tb/tb_ram_rom_mem.sv
module tb_ram_rom_mem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef RAMROM_CLEAR_EN
  logic clr_req = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  logic [3:0] model [0:7];
  logic [4:0] exp_q [$];   // {err, rdata}

  ram_rom_mem_if #(.DATA_W(4), .ADDR_W(3)) bus ();

  ram_rom_mem #(.DATA_W(4), .ADDR_W(3), .ROM_DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef RAMROM_CLEAR_EN
    .clr_req (clr_req),
`endif
    .busy    (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Scoreboard consumer: every response pops one expectation
  always @(negedge clk) begin
    logic [4:0] e;
    total++;
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got err=%0b rdata=%h, required no response", bus.rsp_err, bus.rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.rsp_err, bus.rsp_rdata} !== e) begin
          bad++;
          $display("FAIL rsp_data: got err=%0b rdata=%h, required err=%0b rdata=%h",
                   bus.rsp_err, bus.rsp_rdata, e[4], e[3:0]);
        end
      end
    end else if ({bus.rsp_err, bus.rsp_rdata} !== 5'd0) begin
      bad++;
      $display("FAIL rsp_idle_zero: got err=%0b rdata=%h, required 0/0", bus.rsp_err, bus.rsp_rdata);
    end
  end

  function automatic void model_init();
    model[0] = 4'h4; model[1] = 4'hC; model[2] = 4'h6; model[3] = 4'h7;
    for (int i = 4; i < 8; i++) model[i] = 4'h0;
  endfunction

  // Drive one request at a negedge; expectation pushed only if it will be accepted
  task automatic send(input logic we, input logic [2:0] addr, input logic [3:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    if (bus.req_ready) begin
      if (we) begin
        if (addr < 3'd4) exp_q.push_back({1'b1, 4'h0});
        else begin
          model[addr] = wdata;
          exp_q.push_back({1'b0, 4'h0});
        end
      end else begin
        exp_q.push_back({1'b0, model[addr]});
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending: %0d responses missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Counts busy samples from the current negedge until ready, bounded
  task automatic count_init(input string name);
    int cnt = 0;
    while (!bus.req_ready && cnt < 20) begin
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL %s_busy: got busy=%0b while not ready, required 1", name, busy);
      end
      cnt++;
      @(negedge clk);
    end
    total++;
    if (cnt != 8) begin
      bad++;
      $display("FAIL %s_init_len: got %0d busy cycles, required 8", name, cnt);
    end
    total++;
    if (busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_run: got busy=%0b ready=%0b, required 0/1", name, busy, bus.req_ready);
    end
    model_init();
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got busy=%0b ready=%0b rsp_valid=%0b, required 1/0/0",
               busy, bus.req_ready, bus.rsp_valid);
    end
    rst_n = 1'b1;
    count_init("reset");
  endtask

  task automatic test_read_all();
    for (int a = 0; a < 8; a++) send(1'b0, 3'(a), 4'h0);
    idle(2);
    check_drained("read_all");
  endtask

  task automatic test_write_read();
    send(1'b1, 3'd5, 4'hA);
    send(1'b0, 3'd5, 4'h0);
    idle(2);
    check_drained("write_read");
  endtask

  task automatic test_rom_protect();
    send(1'b1, 3'd1, 4'h3);
    send(1'b0, 3'd1, 4'h0);
    send(1'b1, 3'd3, 4'h0);
    send(1'b0, 3'd3, 4'h0);
    idle(2);
    check_drained("rom_protect");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    idle(2);
    check_drained("back_to_back");
  endtask

  task automatic test_reset_mid_init();
    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Requests during INIT are ignored and must not touch memory
    send(1'b1, 3'd5, 4'h5);
    send(1'b1, 3'd6, 4'h5);
    send(1'b1, 3'd7, 4'h5);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_init("mid_init");
    for (int a = 4; a < 8; a++) send(1'b0, 3'(a), 4'h0);
    idle(2);
    check_drained("mid_init");
  endtask

  task automatic test_reset_clears_ram();
    send(1'b1, 3'd6, 4'h9);
    send(1'b0, 3'd6, 4'h0);
    idle(2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_init("ram_clear");
    send(1'b0, 3'd6, 4'h0);
    idle(2);
    check_drained("ram_clear");
  endtask

`ifdef RAMROM_CLEAR_EN
  task automatic test_clear();
    send(1'b1, 3'd7, 4'hF);
    clr_req = 1'b1;
    send(1'b0, 3'd2, 4'h0);
    clr_req = 1'b0;
    bus.req_valid = 1'b0;
    count_init("clear");
    send(1'b0, 3'd7, 4'h0);
    send(1'b0, 3'd0, 4'h0);
    idle(2);
    check_drained("clear");
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    model_init();
    test_reset();
    test_read_all();
    test_write_read();
    test_rom_protect();
    test_back_to_back();
    test_reset_mid_init();
    test_reset_clears_ram();
`ifdef RAMROM_CLEAR_EN
    test_clear();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
